axis_buffered_serializer: RTL and testbench
===========================================

Name: axis_buffered_serializer

Overview:
- Stream width down-converter with input buffering.
- Accepts wide words of DATA_NB×DATA_WIDTH bits into a synchronous FIFO.
- Emits each word as DATA_NB consecutive DATA_WIDTH-bit beats on a valid/ready stream.
- Sits between an AXI read-data channel and a narrow processing stream.

Parameters:
- DATA_NB, 2, slices per wide word (≥2).
- DATA_WIDTH, 32, width of one output beat.
- ADDR_WIDTH, 9, FIFO address bits; depth = 2^ADDR_WIDTH words.
- AFULL_OFFSET, 4, almost-full threshold: afull when count ≥ depth − AFULL_OFFSET.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low.
- up_data  input  DATA_NB*DATA_WIDTH  wide input word.
- up_valid  input  1  input word valid.
- up_ready  output  1  input accept; equals ~full.
- down_data  output  DATA_WIDTH  current output slice.
- down_valid  output  1  output slice valid.
- down_ready  input  1  downstream accept.
- count  output  ADDR_WIDTH+1  words held in the FIFO, excluding the staging and serializer registers.
- empty  output  1  FIFO empty.
- full  output  1  count == depth.
- afull  output  1  almost full, per AFULL_OFFSET.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO pointers and count = 0; empty=1, full=0, afull=0, up_ready=1.
  - Staging valid = 0; serializer empty; down_valid=0; down_data=0.
- Push:
  - Occurs on up_valid & up_ready; words are written in order.
  - A push while full is impossible, because up_ready=0.
- Pop:
  - pop = ~stage_valid | ser_ready.
  - On a pop, the FIFO read data is registered into the staging register (one-cycle read latency).
  - stage_valid is updated to ~empty on every pop cycle.
  - A pop while empty does not move pointers and clears stage_valid.
- Simultaneous push and pop:
  - Count is unchanged.
  - On an empty FIFO, a push is not visible to the pop path until the next cycle (no fall-through).
- Pointers: wrap modulo depth; count derives from a separate counter.
- Serializer:
  - Holds one wide word plus a slice index 0..DATA_NB−1.
  - ser_ready = ~busy | (down_valid & down_ready & index==DATA_NB−1). This gives back-to-back words with no bubble.
  - On load: busy=1, index=0.
  - Each accepted beat (down_valid & down_ready) advances index.
  - After the last slice, busy clears unless a new word loads in the same cycle.
  - down_valid = busy.
  - down_data = slice[index]; slice 0 = bits [DATA_WIDTH−1:0] (LSB first).
  - down_data and down_valid are stable while down_valid & ~down_ready.
- Throughput: with down_ready held high, one beat per cycle sustained.
- Latency: first beat appears 2 cycles after the first push into an empty block (FIFO write, stage/pop, serializer load).

Optional Feature:
- Macro: MSB_FIRST_EN.
- Defined: slice 0 = top DATA_WIDTH bits of the word; subsequent slices descend.
- Undefined: LSB-first order, as above.
- Handshake and latency are identical in both cases.

Decomposition:
- Package axis_buffered_serializer_pkg: depth and count-width helper constants, plus the slice-select function.
- Sub-module sync_fifo_core: storage, pointers, count, empty/full/afull, registered read.
- Staging register and serializer live in the top module.

Test Plan:
- Reset then single word 0xBBBBBBBB_AAAAAAAA, down_ready=1 -> beats 0xAAAAAAAA then 0xBBBBBBBB; down_valid low afterwards; empty=1.
- Ten consecutive words, down_ready=1 -> 20 contiguous beats in order, no bubble between words.
- down_ready toggled 1/0 each cycle -> every beat held stable while stalled; no loss or duplication.
- down_ready=0, push until up_ready falls -> full=1 at count=512 (ADDR_WIDTH=9); afull=1 from count=508. Releasing down_ready drains all 512 words in order.
- Assert rst low mid-stream -> down_valid, count and full clear immediately (asynchronously); subsequent traffic restarts cleanly.
- Build with MSB_FIRST_EN -> word 0xBBBBBBBB_AAAAAAAA emits 0xBBBBBBBB first.

Source files
------------

// File: rtl/axis_buffered_serializer_pkg.sv
// axis_buffered_serializer_pkg: shared types and helpers for the buffered serializer.
// Provides the FIFO depth helper, the serializer state type and the slice-offset function.
// Optional build macro MSB_FIRST_EN selects MSB-first slice order in slice_lsb().
package axis_buffered_serializer_pkg;

    typedef enum logic {
        SER_IDLE,
        SER_BUSY
    } ser_state_t;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // Bit offset of slice number idx inside a wide word.
    function automatic int slice_lsb(input int idx, input int nb, input int w);
`ifdef MSB_FIRST_EN
        return (nb - 1 - idx) * w;
`else
        return idx * w;
`endif
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: synchronous FIFO with registered read data and occupancy flags.
// Ports: clk, rst (async active-low), wr_data/wr_en, rd_en/rd_data, count, empty, full, afull.
module sync_fifo_core
    import axis_buffered_serializer_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int ADDR_WIDTH   = 9,
    parameter int AFULL_OFFSET = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  afull
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(DEPTH - AFULL_OFFSET);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  push;
    logic                  pop;

    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;
    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH_C);
    assign afull = (cnt >= AFULL_LVL);

    // Storage needs no reset; contents are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/axis_buffered_serializer.sv
// axis_buffered_serializer: buffered wide-to-narrow stream down-converter.
// Ports: clk, rst (async active-low); up_data/up_valid/up_ready wide input;
// down_data/down_valid/down_ready narrow output; count/empty/full/afull FIFO status.
// Build macro MSB_FIRST_EN: emit the top slice first instead of the bottom slice.
module axis_buffered_serializer
    import axis_buffered_serializer_pkg::*;
#(
    parameter int DATA_NB      = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int AFULL_OFFSET = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_NB*DATA_WIDTH-1:0] up_data,
    input  logic                          up_valid,
    output logic                          up_ready,
    output logic [DATA_WIDTH-1:0]         down_data,
    output logic                          down_valid,
    input  logic                          down_ready,
    output logic [ADDR_WIDTH:0]           count,
    output logic                          empty,
    output logic                          full,
    output logic                          afull
);

    localparam int WW    = DATA_NB * DATA_WIDTH;
    localparam int IDX_W = $clog2(DATA_NB);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_NB - 1);

    logic [WW-1:0]    stage_data;
    logic             stage_valid;
    logic             pop;

    ser_state_t       state;
    ser_state_t       state_n;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;
    logic [WW-1:0]    word;
    logic [WW-1:0]    word_n;
    logic             fire;
    logic             last;
    logic             ser_ready;
    logic             load;

    assign up_ready = ~full;

    // The FIFO's registered read port doubles as the staging register.
    sync_fifo_core #(
        .WIDTH        (WW),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .AFULL_OFFSET (AFULL_OFFSET)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (up_data),
        .wr_en   (up_valid),
        .rd_en   (pop),
        .rd_data (stage_data),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .afull   (afull)
    );

    assign down_valid = (state == SER_BUSY);
    assign fire       = down_valid & down_ready;
    assign last       = (idx == LAST);
    // Accepting the final beat frees the serializer in the same cycle,
    // so the next word loads without a bubble.
    assign ser_ready  = (state == SER_IDLE) | (fire & last);
    assign load       = ser_ready & stage_valid;
    assign pop        = ~stage_valid | ser_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid <= 1'b0;
        end else if (pop) begin
            stage_valid <= ~empty;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        word_n  = word;
        if (load) begin
            state_n = SER_BUSY;
            idx_n   = '0;
            word_n  = stage_data;
        end else if (fire) begin
            if (last) begin
                state_n = SER_IDLE;
            end else begin
                idx_n = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SER_IDLE;
            idx   <= '0;
            word  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            word  <= word_n;
        end
    end

    assign down_data = DATA_WIDTH'(word >> slice_lsb(32'(idx), DATA_NB, DATA_WIDTH));

endmodule

// File: tb/tb_axis_buffered_serializer.sv
// tb_axis_buffered_serializer: randomized self-checking bench with a queue-based beat model.
// Exercises latency, back-to-back words, stalls, fill/drain, async reset and random traffic.
module tb_axis_buffered_serializer;

    localparam int NB    = 2;
    localparam int W     = 32;
    localparam int AW    = 9;
    localparam int AO    = 4;
    localparam int DEPTH = 512;
    localparam int WW    = NB * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [WW-1:0] up_data = '0;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [W-1:0]  down_data;
    logic          down_valid;
    logic          down_ready = 1'b0;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          afull;

    axis_buffered_serializer #(
        .DATA_NB      (NB),
        .DATA_WIDTH   (W),
        .ADDR_WIDTH   (AW),
        .AFULL_OFFSET (AO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .afull      (afull)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           passes = 0;
    int           pushes = 0;
    logic [W-1:0] expq[$];
    logic         stall_prev = 1'b0;
    logic [W-1:0] data_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Slice k of a wide word in emission order.
    function automatic logic [W-1:0] slice_of(input logic [WW-1:0] w, input int k);
        int s;
`ifdef MSB_FIRST_EN
        s = NB - 1 - k;
`else
        s = k;
`endif
        return w[s*W +: W];
    endfunction

    // Compare process: handshakes seen at the negedge complete at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            logic [3:0] fl;
            logic [3:0] fe;
            fl = {afull, full, up_ready, empty};
            fe = {count >= (AW+1)'(DEPTH - AO), count == (AW+1)'(DEPTH),
                  count != (AW+1)'(DEPTH), count == '0};
            check("flags", 64'(fl), 64'(fe));
            if (stall_prev) begin
                check("hold_valid", 64'(down_valid), 64'(1));
                check("hold_data", 64'(down_data), 64'(data_prev));
            end
            if (up_valid && up_ready) begin
                for (int k = 0; k < NB; k++) expq.push_back(slice_of(up_data, k));
                pushes++;
            end
            if (down_valid && down_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL extra_beat: got %0h want none", down_data);
                end else begin
                    check("beat", 64'(down_data), 64'(expq.pop_front()));
                end
            end
            stall_prev = down_valid & ~down_ready;
            data_prev  = down_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        up_valid   = 1'b0;
        down_ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(expq.size()), 64'(0));
        tick();
        tick();
        check({name, "_idle"}, 64'({down_valid, empty}), 64'(2'b01));
    endtask

    logic [W-1:0] first_exp;
    logic [W-1:0] second_exp;

    initial begin
        int hi;
        int rises;
        int base;
        int n;
        logic pv;

`ifdef MSB_FIRST_EN
        first_exp  = 32'hBBBBBBBB;
        second_exp = 32'hAAAAAAAA;
`else
        first_exp  = 32'hAAAAAAAA;
        second_exp = 32'hBBBBBBBB;
`endif

        #12;
        check("rst_out", 64'({down_valid, down_data}), 64'(0));
        check("rst_flags", 64'({count, empty, full, afull, up_ready}),
              64'({10'd0, 1'b1, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single word: latency and slice order.
        up_data    = 64'hBBBBBBBB_AAAAAAAA;
        up_valid   = 1'b1;
        down_ready = 1'b1;
        tick();
        up_valid = 1'b0;
        check("lat_e0", 64'(down_valid), 64'(0));
        tick();
        check("lat_e1", 64'(down_valid), 64'(0));
        tick();
        check("lat_e2", 64'(down_valid), 64'(1));
        check("first_beat", 64'(down_data), 64'(first_exp));
        tick();
        check("second_valid", 64'(down_valid), 64'(1));
        check("second_beat", 64'(down_data), 64'(second_exp));
        tick();
        check("single_done", 64'({down_valid, empty}), 64'(2'b01));

        // Ten back-to-back words: one contiguous run of 20 beats.
        hi = 0;
        rises = 0;
        pv = 1'b0;
        for (int c = 0; c < 35; c++) begin
            if (c < 10) begin
                up_data  = {$urandom, $urandom};
                up_valid = 1'b1;
            end else begin
                up_valid = 1'b0;
            end
            tick();
            if (down_valid) hi++;
            if (down_valid && !pv) rises++;
            pv = down_valid;
        end
        check("burst_beats", 64'(hi), 64'(20));
        check("burst_runs", 64'(rises), 64'(1));

        // Alternating down_ready with random pushes.
        for (int c = 0; c < 300; c++) begin
            down_ready = c[0];
            up_valid   = $urandom_range(0, 1) == 1;
            up_data    = {$urandom, $urandom};
            tick();
        end
        drain("toggle_drain", 2000);

        // Fill to full with the output stalled.
        down_ready = 1'b0;
        base = pushes;
        n = 0;
        while (up_ready && n < 700) begin
            up_data  = {$urandom, $urandom};
            up_valid = 1'b1;
            tick();
            n++;
        end
        up_valid = 1'b0;
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_flags", 64'({full, afull, up_ready}), 64'(3'b110));
        check("full_pushes", 64'(pushes - base), 64'(DEPTH + 2));
        drain("full_drain", 1300);

        // Async reset while full and streaming.
        down_ready = 1'b0;
        n = 0;
        while (up_ready && n < 700) begin
            up_data  = {$urandom, $urandom};
            up_valid = 1'b1;
            tick();
            n++;
        end
        down_ready = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b0;
        expq.delete();
        #1;
        check("arst_valid", 64'(down_valid), 64'(0));
        check("arst_status", 64'({count, full, empty, up_ready}),
              64'({10'd0, 1'b0, 1'b1, 1'b1}));
        up_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("arst_quiet", 64'(down_valid), 64'(0));

        // Random traffic after reset.
        for (int c = 0; c < 1500; c++) begin
            up_valid   = $urandom_range(0, 3) != 0;
            down_ready = $urandom_range(0, 3) != 0;
            up_data    = {$urandom, $urandom};
            tick();
        end
        drain("rand_drain", 2500);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
